// File: rtl/mips_pkg.sv
// Shared MIPS constants and types for the execute-stage HI/LO unit.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

  // Encoding matches func[1:0] of MULT/MULTU/DIV/DIVU.
  typedef enum logic [1:0] {MUL_S, MUL_U, DIV_S, DIV_U} md_op_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative magnitude datapath: radix-2 shift-add multiply or restoring divide,
// one step per cycle over a 64-bit accumulator ({hi,lo} / {rem,quot}).
module muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc
);
  import mips_pkg::*;

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        div_q, div_d;
  logic [32:0] add_sum;
  logic [33:0] sub_diff;

  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + {1'b0, b_q};
    // Partial remainder shifted left by one, minus divisor; bit 33 set means "does not fit".
    sub_diff = {1'b0, acc_q[63:31]} - {2'b00, b_q};
    acc_d    = acc_q;
    b_d      = b_q;
    div_d    = div_q;
    if (load) begin
      acc_d = {32'h0, a};
      b_d   = b;
      div_d = is_div;
    end else if (step) begin
      if (div_q) begin
        if (!sub_diff[33]) acc_d = {sub_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_d = {acc_q[62:0], 1'b0};
      end else begin
        if (acc_q[0]) acc_d = {add_sum, acc_q[31:1]};
        else          acc_d = {1'b0, acc_q[63:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage HI/LO unit: decode, IDLE/RUN/FIX sequencer, sign fix-up,
// architectural HI/LO and the hazard stall for HI/LO ops behind an in-flight mult/div.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  opcode_id_ex,
  input  logic [5:0]  func_id_ex,
  input  logic [31:0] rd0_data_id_ex,
  input  logic [31:0] rd1_data_id_ex,
  output logic        stall,
  output logic        busy,
  output logic [31:0] mf_data,
  output logic        mf_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import mips_pkg::*;

  // Handshake: ex_valid marks a real instruction; stall is the not-ready answer.
  // An instruction is consumed in a cycle where ex_valid=1 and stall=0; while
  // stalled it is held in ID/EX and re-decoded every cycle.

  md_state_t   state_q, state_d;
  md_op_t      op_q, op_d;
  logic [4:0]  count_q, count_d;
  logic        sa_q, sa_d, sb_q, sb_d, bzero_q, bzero_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_special, is_hilo, is_md, signed_op, start;
  logic [31:0] a_mag, b_mag, quot, rem;
  logic [63:0] md_acc, prod;

  assign is_special = ex_valid && (opcode_id_ex == OP_SPECIAL);
  assign is_md      = is_special && (func_id_ex inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign is_hilo    = is_md || (is_special &&
                      (func_id_ex inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO}));
  assign signed_op  = (func_id_ex == F_MULT) || (func_id_ex == F_DIV);
  assign a_mag      = abs32(rd0_data_id_ex, signed_op);
  assign b_mag      = abs32(rd1_data_id_ex, signed_op);
  assign start      = (state_q == IDLE) && is_md;

  assign busy  = (state_q != IDLE);
  assign stall = busy && is_hilo;

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .step   (state_q == RUN),
    .is_div (func_id_ex[1]),
    .a      (a_mag),
    .b      (b_mag),
    .acc    (md_acc)
  );

  // Signed results are rebuilt from magnitudes; remainder follows the dividend.
  assign prod = (op_q == MUL_S && (sa_q ^ sb_q)) ? (~md_acc + 64'd1) : md_acc;
  assign quot = (op_q == DIV_S && (sa_q ^ sb_q)) ? (~md_acc[31:0] + 32'd1) : md_acc[31:0];
  assign rem  = (op_q == DIV_S && sa_q) ? (~md_acc[63:32] + 32'd1) : md_acc[63:32];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mf_data  = '0;
    mf_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = md_op_t'(func_id_ex[1:0]);
          sa_d    = signed_op && rd0_data_id_ex[31];
          sb_d    = signed_op && rd1_data_id_ex[31];
          bzero_d = (rd1_data_id_ex == 32'h0);
          count_d = 5'd31;
          state_d = RUN;
        end else if (is_hilo) begin
          case (func_id_ex)
            F_MTHI: hi_d = rd0_data_id_ex;
            F_MTLO: lo_d = rd0_data_id_ex;
            F_MFHI: begin
              mf_valid = 1'b1;
              mf_data  = hi_q;
            end
            F_MFLO: begin
              mf_valid = 1'b1;
              mf_data  = lo_q;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (count_q == 5'd0) state_d = FIX;
        else                 count_d = count_q - 5'd1;
      end
      FIX: begin
        if (op_q == MUL_S || op_q == MUL_U) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else begin
          hi_d = rem;
          lo_d = bzero_q ? 32'hFFFF_FFFF : quot;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MUL_S;
      count_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bzero_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bzero_q <= bzero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: HI/LO results through an expected queue,
// stall/busy timing, special divides, mid-run reset and operand capture.
module tb_ex_muldiv;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [5:0]  opcode_id_ex;
  logic [5:0]  func_id_ex;
  logic [31:0] rd0_data_id_ex;
  logic [31:0] rd1_data_id_ex;
  logic        stall;
  logic        busy;
  logic [31:0] mf_data;
  logic        mf_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] exp_q[$];

  ex_muldiv dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .opcode_id_ex   (opcode_id_ex),
    .func_id_ex     (func_id_ex),
    .rd0_data_id_ex (rd0_data_id_ex),
    .rd1_data_id_ex (rd1_data_id_ex),
    .stall          (stall),
    .busy           (busy),
    .mf_data        (mf_data),
    .mf_valid       (mf_valid),
    .hi             (hi),
    .lo             (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt);
    ex_valid       = v;
    opcode_id_ex   = op;
    func_id_ex     = fn;
    rd0_data_id_ex = rs;
    rd1_data_id_ex = rt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] rs,
                                        input logic [31:0] rt);
    logic [63:0] r;
    longint      p;
    logic [31:0] q, m;
    r = '0;
    case (fn)
      F_MULT: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        r = 64'(p);
      end
      F_MULTU: r = {32'h0, rs} * {32'h0, rt};
      F_DIV: begin
        if (rt == 32'h0) r = {rs, 32'hFFFF_FFFF};
        else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          q = $signed(rs) / $signed(rt);
          m = $signed(rs) % $signed(rt);
          r = {m, q};
        end
      end
      F_DIVU: begin
        if (rt == 32'h0) r = {rs, 32'hFFFF_FFFF};
        else r = {rs % rt, rs / rt};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue one mult/div, scramble the operand buses while it runs, then compare HI/LO.
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [63:0] exp);
    int   busy_cnt;
    logic stall_seen;
    drive(1'b1, OP_SPECIAL, fn, rs, rt);
    exp_q.push_back(exp);
    sample();
    check("accept_busy", 64'(busy), 64'(0));
    next_cycle();
    drive(1'b0, OP_SPECIAL, F_MFHI, $urandom, $urandom);
    busy_cnt   = 0;
    stall_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (stall) stall_seen = 1'b1;
      if (!busy) break;
      busy_cnt++;
      next_cycle();
      drive(1'b0, OP_SPECIAL, F_MFHI, $urandom, $urandom);
    end
    check("busy_cycles", 64'(busy_cnt), 64'(33));
    check("bubble_no_stall", 64'(stall_seen), 64'(0));
    check(tag, {hi, lo}, exp_q.pop_front());
    next_cycle();
  endtask

  initial begin
    int stall_cnt;
    logic [5:0]  fn;
    logic [31:0] rs, rt;

    rst = 1'b1;
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sample();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_mf", {31'h0, mf_valid, mf_data}, 64'h0);

    // MTHI/MTLO then MFHI/MFLO in IDLE.
    next_cycle();
    drive(1'b1, OP_SPECIAL, F_MTHI, 32'h1111_2222, 32'h0);
    next_cycle();
    drive(1'b1, OP_SPECIAL, F_MTLO, 32'h3333_4444, 32'h0);
    next_cycle();
    drive(1'b1, OP_SPECIAL, F_MFHI, 32'h0, 32'h0);
    sample();
    check("mfhi", {31'h0, mf_valid, mf_data}, {31'h0, 1'b1, 32'h1111_2222});
    next_cycle();
    drive(1'b1, OP_SPECIAL, F_MFLO, 32'h0, 32'h0);
    sample();
    check("mflo", {31'h0, mf_valid, mf_data}, {31'h0, 1'b1, 32'h3333_4444});
    next_cycle();
    drive(1'b1, 6'h23, F_MFHI, 32'h0, 32'h0);
    sample();
    check("non_special_mf", 64'(mf_valid), 64'(0));
    next_cycle();
    drive(1'b1, 6'h23, F_MTHI, 32'hDEAD_BEEF, 32'h0);
    next_cycle();
    drive(1'b0, OP_SPECIAL, F_MFHI, 32'h0, 32'h0);
    sample();
    check("non_special_mt", 64'(hi), 64'h1111_2222);
    check("bubble_mf", 64'(mf_valid), 64'(0));
    next_cycle();

    // MULT -2*3 with a dependent MFHI held from T+1.
    drive(1'b1, OP_SPECIAL, F_MULT, 32'hFFFF_FFFE, 32'h3);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    sample();
    check("mult_accept_stall", 64'(stall), 64'(0));
    next_cycle();
    drive(1'b1, OP_SPECIAL, F_MFHI, 32'h0, 32'h0);
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (!stall) break;
      if (stall_cnt == 0) check("mf_while_stalled", {31'h0, mf_valid, mf_data}, 64'h0);
      stall_cnt++;
      next_cycle();
    end
    check("mfhi_stall_cycles", 64'(stall_cnt), 64'(33));
    check("mfhi_after_mult", {31'h0, mf_valid, mf_data}, {31'h0, 1'b1, 32'hFFFF_FFFF});
    check("mult_neg", {hi, lo}, exp_q.pop_front());
    next_cycle();
    drive(1'b0, OP_SPECIAL, 6'h00, 32'h0, 32'h0);

    run_md("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_md("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md("divu_7_2", F_DIVU, 32'h7, 32'h2, {32'h1, 32'h3});
    run_md("div_by_zero", F_DIV, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF});
    run_md("divu_by_zero", F_DIVU, 32'hF000_0001, 32'h0, {32'hF000_0001, 32'hFFFF_FFFF});
    run_md("div_neg_by_zero", F_DIV, 32'h8765_4321, 32'h0, {32'h8765_4321, 32'hFFFF_FFFF});
    run_md("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_md("div_7_m2", F_DIV, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});

    for (int k = 0; k < 6; k++) begin
      fn = F_MULT + 6'($urandom_range(0, 3));
      rs = $urandom;
      rt = (k % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (k == 5) rs = 32'($urandom_range(0, 50));
      run_md("random_md", fn, rs, rt, model(fn, rs, rt));
    end

    // Reset during RUN cycle 10 of a DIVU.
    drive(1'b1, OP_SPECIAL, F_MTHI, 32'hDEAD_0001, 32'h0);
    next_cycle();
    drive(1'b1, OP_SPECIAL, F_MTLO, 32'hBEEF_0002, 32'h0);
    next_cycle();
    drive(1'b1, OP_SPECIAL, F_DIVU, 32'd100, 32'd7);
    next_cycle();
    drive(1'b0, OP_SPECIAL, 6'h00, 32'h0, 32'h0);
    repeat (9) next_cycle();
    rst = 1'b1;
    sample();
    check("busy_before_rst", 64'(busy), 64'(1));
    next_cycle();
    rst = 1'b0;
    drive(1'b1, OP_SPECIAL, F_MFHI, 32'h0, 32'h0);
    sample();
    check("rst_run_busy", 64'(busy), 64'(0));
    check("rst_run_stall", 64'(stall), 64'(0));
    check("rst_run_hilo", {hi, lo}, 64'h0);
    check("rst_run_mf", {31'h0, mf_valid, mf_data}, {31'h0, 1'b1, 32'h0});
    next_cycle();
    drive(1'b0, OP_SPECIAL, 6'h00, 32'h0, 32'h0);
    repeat (30) next_cycle();
    sample();
    check("rst_no_writeback", {hi, lo}, 64'h0);
    check("rst_stays_idle", 64'(busy), 64'(0));
    next_cycle();

    // MULT, independent ADD at T+1, MTLO at T+2 waits and overrides LO.
    drive(1'b1, OP_SPECIAL, F_MULT, 32'd5, 32'd7);
    exp_q.push_back({32'h0, 32'd35});
    sample();
    check("mult2_accept_stall", 64'(stall), 64'(0));
    next_cycle();
    drive(1'b1, OP_SPECIAL, 6'h20, 32'h1, 32'h2);
    sample();
    check("add_no_stall", 64'(stall), 64'(0));
    check("add_busy", 64'(busy), 64'(1));
    next_cycle();
    drive(1'b1, OP_SPECIAL, F_MTLO, 32'hA5A5_A5A5, 32'h0);
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (!stall) break;
      stall_cnt++;
      next_cycle();
    end
    check("mtlo_stall_cycles", 64'(stall_cnt), 64'(32));
    check("mult_5_7", {hi, lo}, exp_q.pop_front());
    next_cycle();
    drive(1'b0, OP_SPECIAL, 6'h00, 32'h0, 32'h0);
    sample();
    check("mtlo_override", {hi, lo}, {32'h0, 32'hA5A5_A5A5});
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
